clock_time_counter: RTL and testbench

- BCD time-of-day counter for the clock project; sits directly upstream of the per-digit 7-segment decoders.
- Produces six 4-bit BCD digits (HH:MM:SS, 24-hour), each wired straight to one decoder instance.
- Derives a 1 Hz tick from the system clock with an internal prescaler.
- Supports manual hour and minute setting from two debounced push-button levels, using a small mode state machine.

---
 rtl/clock_time_counter.sv | 176 +++++++++++++++++
 tb/tb_clock_time_counter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// BCD 24-hour time-of-day counter with 1 Hz prescaler and manual hour/minute set.
module clock_time_counter #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mode_btn,
  input  logic       i_inc_btn,
  output logic [3:0] o_hr_hi,
  output logic [3:0] o_hr_lo,
  output logic [3:0] o_min_hi,
  output logic [3:0] o_min_lo,
  output logic [3:0] o_sec_hi,
  output logic [3:0] o_sec_lo,
  output logic [1:0] o_mode,
  output logic       o_tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_prev_q, inc_prev_q;
  logic          mode_press, inc_press;
  logic          tick_d;

  logic [3:0] hr_hi_d, hr_lo_d, min_hi_d, min_lo_d, sec_hi_d, sec_lo_d;

  // Incremented digit candidates, each with its natural wrap.
  logic [3:0] sec_hi_inc, sec_lo_inc, min_hi_inc, min_lo_inc, hr_hi_inc, hr_lo_inc;
  logic       sec_wrap, min_wrap;

  // Rising-edge detection on the already-debounced button levels.
  assign mode_press = i_mode_btn & ~mode_prev_q;
  assign inc_press  = i_inc_btn  & ~inc_prev_q;

  // BCD incrementers for seconds (mod 60), minutes (mod 60) and hours (mod 24).
  always_comb begin
    sec_hi_inc = o_sec_hi;
    sec_lo_inc = o_sec_lo + 4'd1;
    sec_wrap   = 1'b0;
    if (o_sec_lo == 4'd9) begin
      sec_lo_inc = 4'd0;
      if (o_sec_hi == 4'd5) begin
        sec_hi_inc = 4'd0;
        sec_wrap   = 1'b1;
      end else begin
        sec_hi_inc = o_sec_hi + 4'd1;
      end
    end

    min_hi_inc = o_min_hi;
    min_lo_inc = o_min_lo + 4'd1;
    min_wrap   = 1'b0;
    if (o_min_lo == 4'd9) begin
      min_lo_inc = 4'd0;
      if (o_min_hi == 4'd5) begin
        min_hi_inc = 4'd0;
        min_wrap   = 1'b1;
      end else begin
        min_hi_inc = o_min_hi + 4'd1;
      end
    end

    hr_hi_inc = o_hr_hi;
    hr_lo_inc = o_hr_lo + 4'd1;
    if (o_hr_hi == 4'd2 && o_hr_lo == 4'd3) begin
      hr_hi_inc = 4'd0;
      hr_lo_inc = 4'd0;
    end else if (o_hr_lo == 4'd9) begin
      hr_hi_inc = o_hr_hi + 4'd1;
      hr_lo_inc = 4'd0;
    end
  end

  // Mode FSM next state, prescaler and digit updates; mode press beats inc press.
  always_comb begin
    mode_d   = mode_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    hr_hi_d  = o_hr_hi;
    hr_lo_d  = o_hr_lo;
    min_hi_d = o_min_hi;
    min_lo_d = o_min_lo;
    sec_hi_d = o_sec_hi;
    sec_lo_d = o_sec_lo;

    unique case (mode_q)
      RUN: begin
        if (presc_q == PMAX) begin
          presc_d  = '0;
          tick_d   = 1'b1;
          sec_hi_d = sec_hi_inc;
          sec_lo_d = sec_lo_inc;
          if (sec_wrap) begin
            min_hi_d = min_hi_inc;
            min_lo_d = min_lo_inc;
            if (min_wrap) begin
              hr_hi_d = hr_hi_inc;
              hr_lo_d = hr_lo_inc;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (mode_press) begin
          mode_d  = SET_HR;
          presc_d = '0;
        end
      end
      SET_HR: begin
        presc_d = '0;
        if (mode_press) begin
          mode_d = SET_MIN;
        end else if (inc_press) begin
          hr_hi_d = hr_hi_inc;
          hr_lo_d = hr_lo_inc;
        end
      end
      SET_MIN: begin
        presc_d = '0;
        if (mode_press) begin
          mode_d   = RUN;
          sec_hi_d = 4'd0;
          sec_lo_d = 4'd0;
        end else if (inc_press) begin
          min_hi_d = min_hi_inc;
          min_lo_d = min_lo_inc;
        end
      end
      default: begin
        mode_d  = RUN;
        presc_d = '0;
      end
    endcase
  end

  // State, digit and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q      <= RUN;
      presc_q     <= '0;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      o_tick      <= 1'b0;
      o_hr_hi     <= 4'd0;
      o_hr_lo     <= 4'd0;
      o_min_hi    <= 4'd0;
      o_min_lo    <= 4'd0;
      o_sec_hi    <= 4'd0;
      o_sec_lo    <= 4'd0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      mode_prev_q <= i_mode_btn;
      inc_prev_q  <= i_inc_btn;
      o_tick      <= tick_d;
      o_hr_hi     <= hr_hi_d;
      o_hr_lo     <= hr_lo_d;
      o_min_hi    <= min_hi_d;
      o_min_lo    <= min_lo_d;
      o_sec_hi    <= sec_hi_d;
      o_sec_lo    <= sec_lo_d;
    end
  end

  assign o_mode = mode_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Scoreboard bench for clock_time_counter: integer time-of-day model, per-cycle compare.
module tb_clock_time_counter;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_btn;
  logic       inc_btn;
  logic [3:0] hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo;
  logic [1:0] mode;
  logic       tick;

  clock_time_counter #(.TICK_DIV(TICK_DIV)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mode_btn (mode_btn),
    .i_inc_btn  (inc_btn),
    .o_hr_hi    (hr_hi),
    .o_hr_lo    (hr_lo),
    .o_min_hi   (min_hi),
    .o_min_lo   (min_lo),
    .o_sec_hi   (sec_hi),
    .o_sec_lo   (sec_lo),
    .o_mode     (mode),
    .o_tick     (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [26:0] exp_q[$];

  // Reference model: time as seconds-of-day, mode as 0/1/2, cycle count within the second.
  int m_tod   = 0;
  int m_mode  = 0;
  int m_cnt   = 0;
  int m_tick  = 0;
  int m_pmode = 1;
  int m_pinc  = 1;

  function automatic logic [26:0] pack_exp(int tod, int md, int tk);
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 2'(md), 1'(tk)};
  endfunction

  // Apply one clock's worth of inputs, advance the model and queue the expected outputs.
  task automatic step(input logic r, input logic mb, input logic ib);
    int h, m, s;
    bit mp, ip;
    @(negedge clk);
    rst      = r;
    mode_btn = mb;
    inc_btn  = ib;
    if (r) begin
      m_tod = 0; m_mode = 0; m_cnt = 0; m_tick = 0; m_pmode = 1; m_pinc = 1;
    end else begin
      mp = mb && (m_pmode == 0);
      ip = ib && (m_pinc == 0);
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      s = m_tod % 60;
      m_tick = 0;
      if (m_mode == 0) begin
        if (m_cnt == TICK_DIV - 1) begin
          m_cnt  = 0;
          m_tick = 1;
          m_tod  = (m_tod + 1) % 86400;
        end else begin
          m_cnt = m_cnt + 1;
        end
        if (mp) begin
          m_mode = 1;
          m_cnt  = 0;
        end
      end else if (m_mode == 1) begin
        m_cnt = 0;
        if (mp) m_mode = 2;
        else if (ip) m_tod = ((h + 1) % 24) * 3600 + m * 60 + s;
      end else begin
        m_cnt = 0;
        if (mp) begin
          m_mode = 0;
          m_tod  = h * 3600 + m * 60;
        end else if (ip) begin
          m_tod = h * 3600 + ((m + 1) % 60) * 60 + s;
        end
      end
      m_pmode = mb ? 1 : 0;
      m_pinc  = ib ? 1 : 0;
    end
    exp_q.push_back(pack_exp(m_tod, m_mode, m_tick));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_mode();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: after every active edge, compare outputs to the queued expectation and check ranges.
  initial begin
    logic [26:0] exp_v, act_v;
    bit legal;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo, mode, tick};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cyc=%0d got %0h%0h:%0h%0h:%0h%0h mode=%0d tick=%0b exp %0h%0h:%0h%0h:%0h%0h mode=%0d tick=%0b",
                   cyc, hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo, mode, tick,
                   exp_v[26:23], exp_v[22:19], exp_v[18:15], exp_v[14:11],
                   exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
        end
        legal = (hr_hi <= 4'd2) && (hr_lo <= 4'd9) && !(hr_hi == 4'd2 && hr_lo > 4'd3) &&
                (min_hi <= 4'd5) && (min_lo <= 4'd9) && (sec_hi <= 4'd5) &&
                (sec_lo <= 4'd9) && (mode != 2'd3);
        checks++;
        if (!legal) begin
          errors++;
          $display("FAIL range cyc=%0d got %0h%0h:%0h%0h:%0h%0h mode=%0d exp legal BCD",
                   cyc, hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo, mode);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized button/reset activity.
  initial begin
    logic mb, ib, r;
    rst = 1'b1;
    mode_btn = 1'b0;
    inc_btn = 1'b0;

    // Reset, then first ticks
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(10);

    // Set 23:59, return to RUN, roll over through midnight
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(59);
    press_mode();
    idle(60 * TICK_DIV + 6);

    // SET_HR from 00:00:00, 25 increments -> 01
    step(1'b1, 1'b0, 1'b0);
    press_mode();
    press_inc(25);
    idle(5);

    // SET_MIN with minutes at 59, one more -> 00
    press_mode();
    press_inc(59);
    press_inc(1);
    press_mode();
    idle(6);

    // Simultaneous mode+inc in RUN, then held inc in SET_HR
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    press_mode();
    press_mode();
    idle(3);

    // Reset during SET_MIN at 12:34 with both buttons held
    step(1'b1, 1'b0, 1'b0);
    press_mode();
    press_inc(12);
    press_mode();
    press_inc(34);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    press_mode();
    press_inc(3);
    idle(4);

    // Randomized buttons with occasional resets
    mb = 1'b0;
    ib = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) mb = ~mb;
      if ($urandom_range(0, 2) == 0) ib = ~ib;
      r = ($urandom_range(0, 399) == 0);
      step(r, mb, ib);
    end
    idle(4 * TICK_DIV);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
